// File: rtl/lfsr_decrypt_pkg.sv
// Shared constants, state encoding and LFSR step
// function for the LFSR stream-cipher blocks.
package lfsr_decrypt_pkg;

  localparam int PRE_LEN    = 4;
  localparam int BYTE_STEPS = 8;

  localparam int CNT_W  = $clog2(PRE_LEN);
  localparam int STEP_W = $clog2(BYTE_STEPS);

  localparam logic [CNT_W-1:0]  CNT_LAST  =
    CNT_W'(PRE_LEN - 1);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(BYTE_STEPS - 1);

  localparam int TAP0 = 2;
  localparam int TAP1 = 5;
  localparam int TAP2 = 6;
  localparam int TAP3 = 12;
  localparam int TAP4 = 30;

  // RUN is the idle sub-mode of stepping:
  // waiting for the next payload byte.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_RUN,
    ST_STEP,
    ST_OUT
  } state_e;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s
  );
    logic fb;
    fb = s[TAP0] ^ s[TAP1] ^ s[TAP2]
       ^ s[TAP3] ^ s[TAP4];
    return {s[30:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_decrypt_if.sv
// Byte-stream handshake bundle: ciphertext in,
// plaintext out, both valid/ready.
interface lfsr_decrypt_if;

  logic [7:0] cin;
  logic       cin_valid;
  logic       cin_ready;
  logic [7:0] pout;
  logic       pout_valid;
  logic       pout_ready;

  modport master (
    output cin,
    output cin_valid,
    input  cin_ready,
    input  pout,
    input  pout_valid,
    output pout_ready
  );

  modport slave (
    input  cin,
    input  cin_valid,
    output cin_ready,
    output pout,
    output pout_valid,
    input  pout_ready
  );

endinterface

// File: rtl/lfsr_decrypt_core.sv
// 32-bit LFSR register with clear, parallel load
// and single-step controls (clear > load > step).
module lfsr_step_core
  import lfsr_decrypt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] s_q;
  logic [31:0] s_d;

  // next register value by control priority
  always_comb begin
    s_d = s_q;
    unique case (1'b1)
      clr_i:   s_d = '0;
      load_i:  s_d = load_val_i;
      step_i:  s_d = lfsr_next(s_q);
      default: s_d = s_q;
    endcase
  end

  // LFSR register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign state_o = s_q;

endmodule

// File: rtl/lfsr_decrypt.sv
// Stream-cipher receiver: recovers LFSR state from a
// known preamble, then decrypts payload bytes.
module lfsr_decrypt
  import lfsr_decrypt_pkg::*;
#(
  parameter logic [7:0] PRE_BYTE = 8'h5F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  lfsr_decrypt_if.slave     bus,
  output logic              seed_valid,
  output logic [31:0]       lfsr_state
);

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [STEP_W-1:0] step_cnt_q;
  logic [STEP_W-1:0] step_cnt_d;
  logic [7:0]        cbuf_q;
  logic [7:0]        cbuf_d;
  logic              seed_q;
  logic              seed_d;
  logic              pv_q;
  logic              pv_d;
  logic [7:0]        pout_q;
  logic [7:0]        pout_d;

  logic        cin_ready;
  logic        acc;
  logic        core_load;
  logic        core_step;
  logic [31:0] s;
  logic [31:0] s_nx;
  logic [31:0] load_val;

  assign acc      = bus.cin_valid & cin_ready;
  assign s_nx     = lfsr_next(s);
  // each recovered keystream byte shifts in low
  assign load_val = {s[23:0], bus.cin ^ PRE_BYTE};

  lfsr_step_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start),
    .load_i     (core_load),
    .load_val_i (load_val),
    .step_i     (core_step),
    .state_o    (s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; start overrides everything
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_COLLECT;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_COLLECT:
          if (acc && cnt_q == CNT_LAST)
            state_d = ST_RUN;
        ST_RUN:
          if (acc) state_d = ST_STEP;
        ST_STEP:
          if (step_cnt_q == STEP_LAST)
            state_d = ST_OUT;
        ST_OUT:
          if (bus.pout_ready) state_d = ST_RUN;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: input ready and core controls
  always_comb begin
    cin_ready = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    if (!start) begin
      unique case (state_q)
        ST_COLLECT: begin
          cin_ready = 1'b1;
          core_load = bus.cin_valid;
        end
        ST_RUN:  cin_ready = 1'b1;
        ST_STEP: core_step = 1'b1;
        default: cin_ready = 1'b0;
      endcase
    end
  end

  // datapath next values: counters, buffer, flags
  always_comb begin
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    cbuf_d     = cbuf_q;
    seed_d     = seed_q;
    pv_d       = pv_q;
    pout_d     = pout_q;
    if (start) begin
      cnt_d      = '0;
      step_cnt_d = '0;
      cbuf_d     = '0;
      seed_d     = 1'b0;
      pv_d       = 1'b0;
    end else begin
      unique case (state_q)
        ST_COLLECT:
          if (acc) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST)
              seed_d = 1'b1;
          end
        ST_RUN:
          if (acc) begin
            cbuf_d     = bus.cin;
            step_cnt_d = '0;
          end
        ST_STEP: begin
          step_cnt_d = step_cnt_q + 1'b1;
          if (step_cnt_q == STEP_LAST) begin
            pv_d   = 1'b1;
            pout_d = cbuf_q ^ s_nx[7:0];
          end
        end
        ST_OUT:
          if (bus.pout_ready) pv_d = 1'b0;
        default: pv_d = pv_q;
      endcase
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      step_cnt_q <= '0;
      cbuf_q     <= '0;
      seed_q     <= 1'b0;
      pv_q       <= 1'b0;
      pout_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      cbuf_q     <= cbuf_d;
      seed_q     <= seed_d;
      pv_q       <= pv_d;
      pout_q     <= pout_d;
    end
  end

  assign bus.cin_ready  = cin_ready;
  assign bus.pout       = pout_q;
  assign bus.pout_valid = pv_q;
  assign seed_valid     = seed_q;
  assign lfsr_state     = s;

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Scoreboard bench for lfsr_decrypt: reference
// keystream model, random payloads, directed cases.
module tb_lfsr_decrypt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        seed_valid;
  logic [31:0] lfsr_state;

  lfsr_decrypt_if bus ();

  lfsr_decrypt #(.PRE_BYTE(8'h5F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus.slave),
    .seed_valid (seed_valid),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] model_s;
  bit          rdy_rand = 1'b0;
  bit          rdy_force = 1'b1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(
    input logic [31:0] s);
    int taps[5] = '{2, 5, 6, 12, 30};
    logic fb = 1'b0;
    foreach (taps[i]) fb = fb ^ s[taps[i]];
    return {s[30:0], fb};
  endfunction

  // consumer ready: forced value or random
  always @(posedge clk) begin
    #1;
    if (rdy_rand)
      bus.pout_ready = ($urandom_range(0, 3) != 0);
    else
      bus.pout_ready = rdy_force;
  end

  // monitor: pops expectation on each handshake
  bit         hold_prev = 1'b0;
  logic [7:0] hold_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        check("hold_valid", {31'd0, bus.pout_valid}, 1);
        check("hold_data", {24'd0, bus.pout},
              {24'd0, hold_data});
      end
      if (bus.pout_valid && bus.pout_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %h expected none",
                   bus.pout);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("pout", {24'd0, bus.pout}, {24'd0, e});
        end
      end
      hold_prev = bus.pout_valid && !bus.pout_ready;
      hold_data = bus.pout;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b,
                      output bit ok);
    ok = 1'b0;
    bus.cin = b;
    bus.cin_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.cin_ready) begin
        @(posedge clk);
        #1;
        bus.cin_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.cin_valid = 1'b0;
    checks++;
    failures++;
    $display("FAIL cin_timeout: got no ready expected ready");
  endtask

  task automatic send_pre(input logic [7:0] b);
    bit ok;
    send(b, ok);
    if (ok) model_s = {model_s[23:0], b ^ 8'h5F};
  endtask

  task automatic send_pay(input logic [7:0] b);
    bit ok;
    send(b, ok);
    if (ok) begin
      for (int i = 0; i < 8; i++)
        model_s = ref_step(model_s);
      exp_q.push_back(b ^ model_s[7:0]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_s = '0;
    exp_q.delete();
  endtask

  task automatic drain();
    for (int n = 0; n < 500; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    logic [7:0] p;
    bus.cin = '0;
    bus.cin_valid = 1'b0;
    model_s = '0;
    #23;
    check("rst_cin_ready", {31'd0, bus.cin_ready}, 0);
    check("rst_pout_valid", {31'd0, bus.pout_valid}, 0);
    check("rst_pout", {24'd0, bus.pout}, 0);
    check("rst_seed", {31'd0, seed_valid}, 0);
    check("rst_state", lfsr_state, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'd0, bus.cin_ready}, 0);
    @(posedge clk);
    #1;

    // known preamble -> 0x12345678
    pulse_start();
    send_pre(8'h4D);
    send_pre(8'h6B);
    send_pre(8'h09);
    check("seed_early", {31'd0, seed_valid}, 0);
    send_pre(8'h27);
    check("seed_state", lfsr_state, 32'h12345678);
    check("seed_valid", {31'd0, seed_valid}, 1);
    check("model_seed", model_s, 32'h12345678);

    // payload latency and value
    send_pay(8'hD7);
    k = 1;
    while (k <= 20) begin
      @(negedge clk);
      if (bus.pout_valid) break;
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", k, 9);
    check("pout_A", {24'd0, bus.pout}, 32'h41);
    check("step_state", lfsr_state, 32'h34567896);
    @(posedge clk);
    #1;
    drain();

    // zero state: plaintext equals ciphertext
    pulse_start();
    repeat (4) send_pre(8'h5F);
    check("zero_state", lfsr_state, 0);
    send_pay(8'h3C);
    send_pay(8'hA5);
    drain();
    check("zero_after", lfsr_state, 0);

    // backpressure hold in OUT
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    send_pay(8'h5A);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.pout_valid) break;
    end
    p = bus.pout;
    check("hold_seen", {31'd0, bus.pout_valid}, 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("hold_v", {31'd0, bus.pout_valid}, 1);
      check("hold_p", {24'd0, bus.pout}, {24'd0, p});
      check("hold_rdy", {31'd0, bus.cin_ready}, 0);
    end
    rdy_force = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rel_valid", {31'd0, bus.pout_valid}, 0);
    check("rel_rdy", {31'd0, bus.cin_ready}, 1);
    check("rel_left", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // start during COLLECT with a byte offered
    pulse_start();
    send_pre(8'h11);
    send_pre(8'h22);
    start = 1'b1;
    bus.cin = 8'hAA;
    bus.cin_valid = 1'b1;
    @(negedge clk);
    check("start_rdy", {31'd0, bus.cin_ready}, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.cin_valid = 1'b0;
    model_s = '0;
    exp_q.delete();
    check("start_state", lfsr_state, 0);
    check("start_seed", {31'd0, seed_valid}, 0);
    send_pre(8'h01);
    send_pre(8'h02);
    send_pre(8'h03);
    check("fresh_seed3", {31'd0, seed_valid}, 0);
    send_pre(8'h04);
    check("fresh_seed4", {31'd0, seed_valid}, 1);
    check("fresh_state", lfsr_state, model_s);
    send_pay(8'h77);
    drain();

    // random messages with random backpressure
    rdy_rand = 1'b1;
    for (int m = 0; m < 6; m++) begin
      int len;
      pulse_start();
      for (int i = 0; i < 4; i++)
        send_pre(8'($urandom_range(0, 255)));
      check("rnd_seed", lfsr_state, model_s);
      len = $urandom_range(2, 8);
      for (int i = 0; i < len; i++)
        send_pay(8'($urandom_range(0, 255)));
      drain();
      repeat (3) @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of STEP
    pulse_start();
    repeat (4) send_pre(8'($urandom_range(0, 255)));
    send_pay(8'h99);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_cin_ready", {31'd0, bus.cin_ready}, 0);
    check("mid_pout_valid", {31'd0, bus.pout_valid}, 0);
    check("mid_pout", {24'd0, bus.pout}, 0);
    check("mid_seed", {31'd0, seed_valid}, 0);
    check("mid_state", lfsr_state, 0);
    exp_q.delete();
    model_s = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_idle_rdy", {31'd0, bus.cin_ready}, 0);
      check("post_idle_pv", {31'd0, bus.pout_valid}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
